// File: rtl/btn_stepper.sv
// rtl/btn_stepper.sv - debounced pushbutton to one-cycle step pulses with hold-to-auto-repeat
module btn_stepper #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_RATE     = 3500000,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic step
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } state_t;

    logic              sync_meta;
    logic              sync_btn;
    logic              btn_level;
    logic [DB_W-1:0]   db_cnt;
    logic              pressed_d;
    logic              rise;
    logic              fall;
    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_btn  <= 1'b1;
        end else begin
            sync_meta <= btn_n;
            sync_btn  <= sync_meta;
        end
    end

    assign btn_level = ~sync_btn;

    // The counter only advances while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= '0;
            pressed   <= 1'b0;
            pressed_d <= 1'b0;
        end else begin
            pressed_d <= pressed;
            if (btn_level != pressed) begin
                if (db_cnt == DB_LAST) begin
                    pressed <= btn_level;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise = pressed & ~pressed_d;
    assign fall = ~pressed & pressed_d;

    // Release is checked first so a coinciding repeat step is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
            if (fall) begin
                state         <= IDLE;
                hold_cnt      <= '0;
                release_pulse <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state       <= HOLD_DELAY;
                            hold_cnt    <= '0;
                            press_pulse <= 1'b1;
                            step        <= 1'b1;
                        end
                    end
                    HOLD_DELAY: begin
                        if (REPEAT_EN != 0) begin
                            if (hold_cnt == DELAY_LAST) begin
                                step     <= 1'b1;
                                state    <= HOLD_REPEAT;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD_REPEAT: begin
                        if (hold_cnt == RATE_LAST) begin
                            step     <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
